// File: rtl/apb_demux_pkg.sv
// Shared types for the APB peripheral demultiplexer and its address decoder.
package apb_demux_pkg;

    localparam int unsigned MAX_SLV = 16;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] size;
    } addr_rule_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        DECODE  = 2'd1,
        TIMEOUT = 2'd2,
        SLVERR  = 2'd3
    } err_kind_e;

endpackage

// File: rtl/soc_bus_pkg.sv
// SoC-level APB request/response structs shared by bridges, interconnect and peripherals.
package soc_bus_pkg;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [2:0]  pprot;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } soc_apb_req_t;

    typedef struct packed {
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
    } soc_apb_resp_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational {base,size} window match; reports whether any rule hits and the lowest hitting index.
module apb_addr_decode
    import apb_demux_pkg::*;
#(
    parameter int unsigned N_SLV  = 4,
    parameter type         rule_t = addr_rule_t,
    parameter int unsigned IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
    input  logic [31:0]      addr_i,
    input  rule_t            rules_i [N_SLV],
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    // Walk downwards so the lowest matching index is written last; wrapped offset makes size 0 never hit.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr_i - rules_i[i].base) < rules_i[i].size) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_demux.sv
// APB 1-to-N_SLV demultiplexer with runtime address map, decode errors and sticky error capture.
// Define APB_DEMUX_TIMEOUT_EN to include the access-phase watchdog and its TMO completion state.
module apb_periph_demux
    import apb_demux_pkg::*;
#(
    parameter int unsigned N_SLV      = 4,
    parameter int unsigned TMO_CYCLES = 256,
    parameter type         apb_req_t  = soc_bus_pkg::soc_apb_req_t,
    parameter type         apb_rsp_t  = soc_bus_pkg::soc_apb_resp_t,
    parameter type         rule_t     = apb_demux_pkg::addr_rule_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  apb_req_t    mst_req_i,
    output apb_rsp_t    mst_rsp_o,
    output apb_req_t    slv_req_o [N_SLV],
    input  apb_rsp_t    slv_rsp_i [N_SLV],
    input  rule_t       addr_map_i [N_SLV],
    input  logic        err_clr_i,
    output logic        err_valid_o,
    output logic [31:0] err_addr_o,
    output logic [1:0]  err_kind_o
);

    localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TMO    = 2'd2
    } state_e;

    state_e           state_q;
    logic             hit_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      addr_q;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             setup;
    logic             violation;
    apb_rsp_t         sel_rsp;

    logic             err_now;
    err_kind_e        kind_now;
    logic [31:0]      err_addr_now;

    logic             err_valid_q, err_valid_d;
    logic [31:0]      err_addr_q, err_addr_d;
    err_kind_e        err_kind_q, err_kind_d;

    apb_addr_decode #(
        .N_SLV  (N_SLV),
        .rule_t (rule_t),
        .IDX_W  (IDX_W)
    ) u_decode (
        .addr_i  (mst_req_i.paddr),
        .rules_i (addr_map_i),
        .hit_o   (dec_hit),
        .idx_o   (dec_idx)
    );

    assign setup     = mst_req_i.psel && !mst_req_i.penable;
    // Access phase without a preceding setup; gated by reset so outputs stay quiet while held.
    assign violation = rst_ni && (state_q == IDLE) && mst_req_i.psel && mst_req_i.penable;
    assign sel_rsp   = slv_rsp_i[idx_q];

`ifdef APB_DEMUX_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        tmo_hit;

    assign tmo_hit = (cnt_q == 16'(TMO_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && setup) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && hit_q && !sel_rsp.pready && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYCLES;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        state_q <= ACCESS;
                        hit_q   <= dec_hit;
                        idx_q   <= dec_idx;
                        addr_q  <= mst_req_i.paddr;
                    end
                end
                ACCESS: begin
                    if (!hit_q || sel_rsp.pready) begin
                        state_q <= IDLE;
                    end
`ifdef APB_DEMUX_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q <= TMO;
                    end
`endif
                end
                TMO:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only the selected slave sees psel/penable; everything else is broadcast, and reset silences all.
    always_comb begin
        for (int i = 0; i < N_SLV; i++) begin
            slv_req_o[i] = '0;
            if (rst_ni) begin
                slv_req_o[i]         = mst_req_i;
                slv_req_o[i].psel    = 1'b0;
                slv_req_o[i].penable = 1'b0;
                if ((state_q == IDLE && setup && dec_hit && dec_idx == IDX_W'(i)) ||
                    (state_q == ACCESS && hit_q && idx_q == IDX_W'(i))) begin
                    slv_req_o[i].psel    = mst_req_i.psel;
                    slv_req_o[i].penable = mst_req_i.penable;
                end
            end
        end
    end

    always_comb begin
        mst_rsp_o    = '0;
        err_now      = 1'b0;
        kind_now     = NONE;
        err_addr_now = addr_q;
        case (state_q)
            IDLE: begin
                if (violation) begin
                    mst_rsp_o.pready  = 1'b1;
                    mst_rsp_o.pslverr = 1'b1;
                    err_now           = 1'b1;
                    kind_now          = DECODE;
                    err_addr_now      = mst_req_i.paddr;
                end
            end
            ACCESS: begin
                if (!hit_q) begin
                    mst_rsp_o.pready  = 1'b1;
                    mst_rsp_o.pslverr = 1'b1;
                    err_now           = 1'b1;
                    kind_now          = DECODE;
                end else begin
                    mst_rsp_o = sel_rsp;
                    if (sel_rsp.pready && sel_rsp.pslverr) begin
                        err_now  = 1'b1;
                        kind_now = SLVERR;
                    end
                end
            end
            TMO: begin
                mst_rsp_o.pready  = 1'b1;
                mst_rsp_o.pslverr = 1'b1;
                err_now           = 1'b1;
                kind_now          = TIMEOUT;
            end
            default: ;
        endcase
    end

    // Clear is applied first so an error in the same cycle is still captured.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_kind_d  = err_kind_q;
        if (err_clr_i) begin
            err_valid_d = 1'b0;
        end
        if (err_now && !err_valid_d) begin
            err_valid_d = 1'b1;
            err_addr_d  = err_addr_now;
            err_kind_d  = kind_now;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_kind_q  <= NONE;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_kind_q  <= err_kind_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_kind_o  = err_kind_q;

endmodule

// File: tb/tb_apb_periph_demux.sv
// Scoreboard bench for apb_periph_demux; timeout expectations follow APB_DEMUX_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_apb_periph_demux;
    import soc_bus_pkg::*;
    import apb_demux_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 8;
`ifdef APB_DEMUX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    soc_apb_req_t  mreq;
    soc_apb_resp_t mrsp;
    soc_apb_req_t  sreq [N];
    soc_apb_resp_t srsp [N];
    addr_rule_t    amap [N];
    logic          err_clr;
    logic          err_valid;
    logic [31:0]   err_addr;
    logic [1:0]    err_kind;

    always #5 clk = ~clk;

    apb_periph_demux #(
        .N_SLV      (N),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mst_req_i   (mreq),
        .mst_rsp_o   (mrsp),
        .slv_req_o   (sreq),
        .slv_rsp_i   (srsp),
        .addr_map_i  (amap),
        .err_clr_i   (err_clr),
        .err_valid_o (err_valid),
        .err_addr_o  (err_addr),
        .err_kind_o  (err_kind)
    );

    // Slave models: wt[i] wait states, then pready with the configured data/error.
    int          wt   [N];
    logic [31:0] rdat [N];
    logic        serr [N];
    int          acnt [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            srsp[i]        = '0;
            srsp[i].prdata = rdat[i];
            if (sreq[i].psel && sreq[i].penable && acnt[i] == wt[i]) begin
                srsp[i].pready  = 1'b1;
                srsp[i].pslverr = serr[i];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) acnt[i] <= 0;
            else if (sreq[i].psel && sreq[i].penable && !srsp[i].pready) acnt[i] <= acnt[i] + 1;
            else acnt[i] <= 0;
        end
    end

    typedef struct {
        int          slv;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        bit          tmo;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_valid;
    logic [31:0] m_addr;
    logic [1:0]  m_kind;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        logic [31:0] off;
        for (int i = 0; i < N; i++) begin
            off = a - amap[i].base;
            if (amap[i].size != 0 && off < amap[i].size) return i;
        end
        return -1;
    endfunction

    function automatic exp_t predict(input logic [31:0] a, input logic [31:0] wd, output logic [1:0] kind);
        exp_t e;
        int   s;
        s       = ref_decode(a);
        e.slv   = s;
        e.addr  = a;
        e.wdata = wd;
        e.tmo   = 1'b0;
        e.rdata = '0;
        e.err   = 1'b1;
        e.lat   = 1;
        kind    = 2'd1;
        if (s >= 0) begin
            if (TMO_EN && wt[s] >= TMO) begin
                e.tmo = 1'b1;
                e.lat = TMO + 1;
                kind  = 2'd2;
            end else begin
                e.rdata = rdat[s];
                e.err   = serr[s];
                e.lat   = wt[s] + 1;
                kind    = serr[s] ? 2'd3 : 2'd0;
            end
        end
        return e;
    endfunction

    task automatic log_err(input logic [1:0] kind, input logic [31:0] a);
        if (kind != 2'd0 && !m_valid) begin
            m_valid = 1'b1;
            m_addr  = a;
            m_kind  = kind;
        end
    endtask

    task automatic check_err(input string tag);
        check({tag, "_err_valid"}, 64'(err_valid), 64'(m_valid));
        check({tag, "_err_addr"}, 64'(err_addr), 64'(m_addr));
        check({tag, "_err_kind"}, 64'(err_kind), 64'(m_kind));
    endtask

    // Monitor: pops the scoreboard whenever the master access phase completes.
    int            acc_cyc = 0;
    exp_t          mon_e;
    logic [N-1:0]  pv, pe;
    bit            bc_ok;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_cyc = 0;
        end else if (mreq.psel && mreq.penable) begin
            acc_cyc++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_access: got access cycle %0d, expected no transfer", acc_cyc);
            end else begin
                mon_e = exp_q[0];
                pe    = '0;
                for (int j = 0; j < N; j++) pv[j] = sreq[j].psel;
                if (mon_e.slv >= 0 && !(mon_e.tmo && acc_cyc == mon_e.lat)) pe[mon_e.slv] = 1'b1;
                check("slave_psel", 64'(pv), 64'(pe));
                if (mrsp.pready) begin
                    check("latency", 64'(acc_cyc), 64'(mon_e.lat));
                    check("prdata", 64'(mrsp.prdata), 64'(mon_e.rdata));
                    check("pslverr", 64'(mrsp.pslverr), 64'(mon_e.err));
                    bc_ok = 1'b1;
                    for (int j = 0; j < N; j++)
                        if (sreq[j].paddr !== mon_e.addr || sreq[j].pwdata !== mon_e.wdata) bc_ok = 1'b0;
                    check("broadcast", 64'(bc_ok), 64'd1);
                    void'(exp_q.pop_front());
                    acc_cyc = 0;
                end
            end
        end else begin
            acc_cyc = 0;
            check("idle_rsp_zero", 64'(mrsp), 64'd0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after completion with the bus idle.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd);
        exp_t       e;
        logic [1:0] k;
        int         guard;
        e = predict(a, wd, k);
        exp_q.push_back(e);
        mreq         = '0;
        mreq.psel    = 1'b1;
        mreq.pwrite  = wr;
        mreq.paddr   = a;
        mreq.pwdata  = wd;
        mreq.pstrb   = 4'hF;
        mreq.pprot   = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1 mreq.penable = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                $display("FAIL completion_timeout: no pready after %0d cycles, addr 0x%0h", guard, a);
                $fatal(1, "bench aborted");
            end
        end while (!mrsp.pready);
        @(posedge clk);
        #1;
        mreq.psel    = 1'b0;
        mreq.penable = 1'b0;
        log_err(k, a);
        check_err("xfer");
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_valid = 1'b0;
        check("err_clr", 64'(err_valid), 64'd0);
    endtask

    task automatic set_slv(input int s, input int w, input logic [31:0] d, input logic e);
        wt[s]   = w;
        rdat[s] = d;
        serr[s] = e;
    endtask

    exp_t        ve;
    logic [31:0] ra;
    int          rs;

    initial begin
        m_valid = 1'b0; m_addr = '0; m_kind = '0;
        err_clr = 1'b0;
        for (int i = 0; i < N; i++) set_slv(i, 0, 32'h1111_0000 + i, 1'b0);
        amap[0] = '{base: 32'h0000_0000, size: 32'h0000_0100};
        amap[1] = '{base: 32'h1000_0000, size: 32'h0000_1000};
        amap[2] = '{base: 32'h0000_0080, size: 32'h0000_0100};
        amap[3] = '{base: 32'hFFFF_F000, size: 32'h0000_2000};

        // Reset with the master driving an access: outputs must stay silent.
        rst_n        = 1'b0;
        mreq         = '0;
        mreq.psel    = 1'b1;
        mreq.penable = 1'b1;
        mreq.paddr   = 32'h1000_0004;
        mreq.pwdata  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) check("reset_slv_req_zero", 64'(sreq[j] == '0), 64'd1);
        check("reset_mst_rsp", 64'(mrsp), 64'd0);
        check_err("reset");
        mreq = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        set_slv(1, 2, 32'hCAFE_F00D, 1'b0);
        xfer(32'h1000_0004, 1'b0, 32'h0);
        xfer(32'h2000_0000, 1'b1, 32'h1234_5678);
        check("unmapped_kind", 64'(err_kind), 64'd1);
        pulse_clr();

        set_slv(1, 8, 32'hAAAA_5555, 1'b0);
        xfer(32'h1000_0010, 1'b0, 32'h0);
        pulse_clr();
        set_slv(1, 7, 32'h5555_AAAA, 1'b0);
        xfer(32'h1000_0020, 1'b0, 32'h0);
        check("race_no_error", 64'(err_valid), 64'd0);

        set_slv(0, 1, 32'h0000_0A0A, 1'b0);
        set_slv(2, 0, 32'h0000_2222, 1'b0);
        xfer(32'h0000_0090, 1'b0, 32'h0);
        set_slv(0, 0, 32'h0BAD_0BAD, 1'b1);
        xfer(32'h0000_0010, 1'b1, 32'h0000_00FF);
        xfer(32'h2000_0000, 1'b0, 32'h0);
        check("first_error_addr", 64'(err_addr), 64'h10);
        check("first_error_kind", 64'(err_kind), 64'd3);
        pulse_clr();

        // Clear held high across a new decode miss: the new error is still captured.
        set_slv(0, 0, 32'h0, 1'b0);
        xfer(32'h3000_0000, 1'b0, 32'h0);
        err_clr = 1'b1;
        m_valid = 1'b0;
        xfer(32'h4000_0000, 1'b0, 32'h0);
        err_clr = 1'b0;
        check("clr_and_new_addr", 64'(err_addr), 64'h4000_0000);

        // Access phase with no setup phase.
        pulse_clr();
        ve = '{slv: -1, rdata: 32'h0, err: 1'b1, lat: 1, tmo: 1'b0, addr: 32'h1000_0000, wdata: 32'h0};
        exp_q.push_back(ve);
        mreq         = '0;
        mreq.psel    = 1'b1;
        mreq.penable = 1'b1;
        mreq.paddr   = 32'h1000_0000;
        @(posedge clk);
        #1 mreq = '0;
        log_err(2'd1, 32'h1000_0000);
        check_err("violation");
        pulse_clr();

        // Wrapping window on slave 3, then disabled by size 0.
        set_slv(3, 1, 32'h3333_3333, 1'b0);
        xfer(32'h0000_0800, 1'b0, 32'h0);
        amap[3].size = 32'h0;
        xfer(32'h0000_0800, 1'b0, 32'h0);
        amap[3].size = 32'h0000_2000;
        pulse_clr();

        // Reset during a long access phase.
        set_slv(1, 20, 32'h7777_7777, 1'b0);
        ve = '{slv: 1, rdata: 32'h0, err: 1'b0, lat: 1000, tmo: 1'b0, addr: 32'h1000_0040, wdata: 32'h0};
        exp_q.push_back(ve);
        mreq       = '0;
        mreq.psel  = 1'b1;
        mreq.paddr = 32'h1000_0040;
        @(posedge clk);
        #1 mreq.penable = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < N; j++) pv[j] = sreq[j].psel;
        check("midreset_psel", 64'(pv), 64'd0);
        check("midreset_mst_rsp", 64'(mrsp), 64'd0);
        check("midreset_err_valid", 64'(err_valid), 64'd0);
        exp_q.delete();
        m_valid = 1'b0; m_addr = '0; m_kind = '0;
        mreq = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic, frequently back-to-back.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < N; i++)
                set_slv(i, $urandom_range(0, 10), $urandom, ($urandom_range(0, 5) == 0));
            rs = $urandom_range(0, N);
            if (rs < N) ra = amap[rs].base + $urandom_range(0, amap[rs].size - 1);
            else ra = $urandom;
            xfer(ra, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 7) == 0) pulse_clr();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_periph_demux.md
# apb_periph_demux

Parametrised APB peripheral demultiplexer. It routes one APB master port to `N_SLV` APB slave ports using a runtime address map, and returns a decode error for unmapped addresses. A per-transfer watchdog forces an error completion if a slave stalls. It sits between the SoC APB bridge and peripherals (UART, debug, accelerator CSR sockets), replacing fixed-window hit logic.

## Interface
Parameters:
- `N_SLV`, 4, number of slave ports (1..16).
- `TMO_CYCLES`, 256, access-phase wait cycles before timeout (≥2).
- `apb_req_t`, `soc_bus_pkg::soc_apb_req_t`, APB request struct.
- `apb_rsp_t`, `soc_bus_pkg::soc_apb_resp_t`, APB response struct.
- `rule_t`, `apb_demux_pkg::addr_rule_t`, {base, size} 32-bit each.

Ports:
- `clk_i`  in  1  clock; the block uses one clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `mst_req_i`  in  apb_req_t  request from the master.
- `mst_rsp_o`  out  apb_rsp_t  response to the master.
- `slv_req_o`  out  [N_SLV] apb_req_t  requests to the slaves.
- `slv_rsp_i`  in  [N_SLV] apb_rsp_t  responses from the slaves.
- `addr_map_i`  in  [N_SLV] rule_t  address windows, quasi-static.
- `err_clr_i`  in  1  clears the error capture.
- `err_valid_o`  out  1  sticky error-captured flag.
- `err_addr_o`  out  32  paddr of the first captured error.
- `err_kind_o`  out  2  error type: 01 decode, 10 timeout, 11 slave pslverr.

## Operation
- **Decode:**
  - Slave i hits when `(paddr - base_i) < size_i`, using unsigned 32-bit arithmetic with wrap.
  - Lowest index wins on overlap.
  - A rule with size 0 never hits.
- **FSM states:** IDLE, ACCESS, TMO.
  - IDLE: on `psel && !penable` (setup), latch the hit index, hit flag and paddr; go to ACCESS.
  - ACCESS, hit: forward to the selected slave; return to IDLE when that slave's pready=1.
  - ACCESS, miss: complete immediately with pready=1, pslverr=1, prdata=0; return to IDLE.
  - ACCESS, hit, slave pready=0 for `TMO_CYCLES` consecutive access cycles: go to TMO.
  - TMO: drive master pready=1, pslverr=1, prdata=0 for one cycle; deassert the slave's psel/penable; go to IDLE.
- **Request fan-out:**
  - In the setup cycle and in ACCESS, the selected slave sees `mst_req_i` unchanged.
  - All other slaves see psel=0 and penable=0.
  - paddr, pwdata, pwrite, pstrb and pprot are broadcast to all slaves.
- **Response:** in ACCESS, `mst_rsp_o` is a combinational copy of the selected slave's response. Outside ACCESS/TMO it is all-zero.
- **Protocol violation:** `psel && penable` seen in IDLE (no setup phase) completes in that cycle with pslverr=1 and is logged as decode.
- **Wait counter:**
  - 16-bit counter, cleared on entry to ACCESS.
  - Increments each ACCESS cycle with pready=0.
  - Saturates; it does not wrap.
- **Simultaneous events:** slave pready=1 in the same cycle the counter reaches `TMO_CYCLES` → the slave response wins and no timeout is raised.
- **Error capture:**
  - Triggers on a completion with pslverr=1.
  - Records paddr and kind only when `err_valid_o`=0; the first error wins.
  - `err_clr_i` clears `err_valid_o`.
  - Clear and a new error in the same cycle → the new error is captured.

## Timing
- Zero added latency: setup → access → completion follows slave timing exactly. A decode miss completes in the first access cycle.
- Timeout error completion occurs in access cycle `TMO_CYCLES+1`.
- Reset values:
  - FSM=IDLE, counter=0.
  - All `slv_req_o` fields 0; `mst_rsp_o` all 0.
  - `err_valid_o`=0, `err_addr_o`=0, `err_kind_o`=0.
- Reset asserted mid-transfer: all slave psel drop asynchronously and the transfer is abandoned with no error logged.
- Back-to-back transfers are allowed: a setup in the cycle after completion is decoded from IDLE.

## Configuration
- `APB_DEMUX_TIMEOUT_EN`
  - Defined: the watchdog and the TMO state are present.
  - Undefined: the counter and TMO are removed, ACCESS waits indefinitely for slave pready, and error kind 10 never occurs.

## Structure
- `apb_demux_pkg` holds:
  - `addr_rule_t`;
  - `err_kind_e` (NONE=0, DECODE=1, TIMEOUT=2, SLVERR=3);
  - `MAX_SLV=16`.
- Sub-module `apb_addr_decode`: combinational rule match producing hit flag and index (`$clog2(N_SLV)` bits, minimum 1). It is reusable by other interconnect.

## Test plan
- **Mapped read:** map slave 1 at 0x1000_0000/0x1000; read 0x1000_0004 with slave 2-wait → only slave 1 psel; prdata=0xCAFE_F00D after 2 waits; pslverr=0.
- **Unmapped write:** write to 0x2000_0000 → pready=1, pslverr=1 in the first access cycle; `err_kind_o`=01, `err_addr_o`=0x2000_0000.
- **Timeout:** `TMO_CYCLES`=8, slave never ready → master pready=1 with pslverr=1 at access cycle 9; slave psel drops; `err_kind_o`=10.
- **Race at limit:** slave pready at access cycle 8 with `TMO_CYCLES`=8 → normal completion, no error logged.
- **Overlap and first-error:** overlapping windows on slaves 0 and 2 → slave 0 selected. Then a slave pslverr at 0x0000_0010 followed by a decode miss → capture keeps 0x0000_0010 and kind 11. `err_clr_i` → `err_valid_o`=0.
- **Mid-transfer reset:** assert `rst_ni` low during ACCESS → all `slv_req_o.psel`=0 immediately; `mst_rsp_o`=0.
